// File: rtl/n_term_s1_share_refresh_pkg.sv
// n_term_share_pkg: shared types, constants and LFSR step function for the share refresh stage
package n_term_share_pkg;
  typedef enum logic {WARMUP, RUN} state_e;
  localparam logic [31:0] LFSR_TAPS_DEFAULT = 32'h8020_0003;
  localparam logic [31:0] SEED_DEFAULT = 32'hACE1_2468;
  function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic [31:0] taps);
    return (s >> 1) ^ (s[0] ? taps : 32'h0);
  endfunction
endpackage

// File: rtl/n_term_s1_share_refresh_lfsr.sv
// share_lfsr: Galois LFSR mask source with seed load (zero seed replaced by default) and step enable
module share_lfsr
  import n_term_share_pkg::*;
#(
  parameter int NUM_PAIRS = 8,
  parameter int LFSR_W = 32,
  parameter logic [LFSR_W-1:0] TAPS = LFSR_TAPS_DEFAULT,
  parameter logic [LFSR_W-1:0] SEED = n_term_share_pkg::SEED_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [LFSR_W-1:0]    seed_i,
  output logic [NUM_PAIRS-1:0] mask_o
);
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  // load beats step so a reseed never gets advanced in its own cycle; zero seed would lock the LFSR
  always_comb lfsr_d = load_i ? ((seed_i == '0) ? SEED : seed_i)
                     : step_i ? LFSR_W'(lfsr_step(32'(lfsr_q), 32'(TAPS))) : lfsr_q;
  // LFSR state register
  always_ff @(posedge clk)
    if (!rst_n) lfsr_q <= SEED;
    else lfsr_q <= lfsr_d;
  assign mask_o = lfsr_q[NUM_PAIRS-1:0];
endmodule

// File: rtl/n_term_s1_share_refresh.sv
// n_term_s1_share_refresh: registered two-share re-masking of the N_term_s1 south-going wires (N_TERM_SHARE_DUAL_STAGE_EN adds an input register, latency 2)
module n_term_s1_share_refresh #(
  parameter int NUM_PAIRS = 8,
  parameter int LFSR_W = 32,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = n_term_share_pkg::LFSR_TAPS_DEFAULT,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = n_term_share_pkg::SEED_DEFAULT
) (
  input  logic                 UserCLK,
  input  logic                 rst_n,
  input  logic [NUM_PAIRS-1:0] from_N_s0,
  input  logic [NUM_PAIRS-1:0] from_N_s1,
  output logic [NUM_PAIRS-1:0] to_S_s0,
  output logic [NUM_PAIRS-1:0] to_S_s1,
  input  logic                 refresh_en,
  input  logic                 seed_valid,
  input  logic [LFSR_W-1:0]    seed_data,
  output logic                 seed_ready,
  output logic                 running
);
  import n_term_share_pkg::*;
  localparam int CW = $clog2(LFSR_W);
  state_e state_q, state_d;
  logic [CW-1:0] warm_q, warm_d;
  logic [NUM_PAIRS-1:0] lfsr_mask, mask, src_s0, src_s1, s0_q, s0_d, s1_q, s1_d;
  logic accept;
  assign running = state_q == RUN;
  assign seed_ready = running;
  assign accept = seed_valid & seed_ready;
  assign mask = refresh_en ? lfsr_mask : '0;
  share_lfsr #(.NUM_PAIRS(NUM_PAIRS), .LFSR_W(LFSR_W), .TAPS(LFSR_TAPS), .SEED(SEED_DEFAULT)) u_lfsr (
    .clk(UserCLK),
    .rst_n(rst_n),
    .load_i(accept),
    .step_i(running ? refresh_en : 1'b1),
    .seed_i(seed_data),
    .mask_o(lfsr_mask)
  );
`ifdef N_TERM_SHARE_DUAL_STAGE_EN
  logic [NUM_PAIRS-1:0] in_s0_q, in_s1_q;
  // capture tile wires before masking so no combinational path reaches the mask XOR
  always_ff @(posedge UserCLK)
    if (!rst_n || accept) {in_s0_q, in_s1_q} <= '0;
    else {in_s0_q, in_s1_q} <= {from_N_s0, from_N_s1};
  assign src_s0 = in_s0_q;
  assign src_s1 = in_s1_q;
`else
  assign src_s0 = from_N_s0;
  assign src_s1 = from_N_s1;
`endif
  // warm-up countdown to RUN; a reseed in RUN restarts the full warm-up
  always_comb begin
    state_d = state_q;
    warm_d = warm_q;
    if (state_q == WARMUP) begin
      warm_d = warm_q - CW'(1);
      state_d = (warm_q == '0) ? RUN : WARMUP;
    end else if (accept) begin
      state_d = WARMUP;
      warm_d = CW'(LFSR_W - 1);
    end
  end
  // same mask on both shares keeps s0^s1 intact; outputs stay 0/0 outside RUN
  always_comb begin
    s0_d = (running && !accept) ? src_s0 ^ mask : '0;
    s1_d = (running && !accept) ? src_s1 ^ mask : '0;
  end
  // FSM and output register stage
  always_ff @(posedge UserCLK)
    if (!rst_n) begin
      state_q <= WARMUP;
      warm_q <= CW'(LFSR_W - 1);
      s0_q <= '0;
      s1_q <= '0;
    end else begin
      state_q <= state_d;
      warm_q <= warm_d;
      s0_q <= s0_d;
      s1_q <= s1_d;
    end
  assign to_S_s0 = s0_q;
  assign to_S_s1 = s1_q;
endmodule

// File: tb/tb_n_term_s1_share_refresh.sv
// tb_n_term_s1_share_refresh: directed self-checking bench with an independent LFSR reference model
module tb_n_term_s1_share_refresh;
`ifdef N_TERM_SHARE_DUAL_STAGE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam logic [31:0] SEED = 32'hACE1_2468;
  logic UserCLK = 0, rst_n, refresh_en, seed_valid, seed_ready, running;
  logic [7:0] from_N_s0, from_N_s1, to_S_s0, to_S_s1;
  logic [31:0] seed_data, r;
  int checks = 0, errors = 0;

  typedef struct {logic en; logic [7:0] a0; logic [7:0] a1; logic [7:0] exp_x;} vec_t;
  vec_t tv[9];

  n_term_s1_share_refresh dut (
    .UserCLK(UserCLK), .rst_n(rst_n), .from_N_s0(from_N_s0), .from_N_s1(from_N_s1),
    .to_S_s0(to_S_s0), .to_S_s1(to_S_s1), .refresh_en(refresh_en), .seed_valid(seed_valid),
    .seed_data(seed_data), .seed_ready(seed_ready), .running(running)
  );

  always #5 UserCLK = ~UserCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge UserCLK);
    #1;
  endtask

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [31:0] ref_warm(input logic [31:0] seed);
    logic [31:0] s = (seed == 32'h0) ? SEED : seed;
    for (int i = 0; i < 32; i++) s = ref_step(s);
    return s;
  endfunction

  // called right after the edge that reset/reseeded; inputs must be A5/0F with refresh on
  task automatic warm_run(input logic [31:0] seed, input int n, output logic [31:0] r_out);
    int cyc = 0;
    logic bad = (to_S_s0 !== 8'h00) || (to_S_s1 !== 8'h00) || (running !== 1'b0);
    logic [31:0] m;
    while (!running && cyc < 40) begin
      tick;
      cyc++;
      if (to_S_s0 !== 8'h00 || to_S_s1 !== 8'h00 || (!running && seed_ready !== 1'b0)) bad = 1;
    end
    chk("warm_outputs_zero", 32'(bad), 0);
    chk("warm_cycles", cyc, 32);
    m = ref_warm(seed);
    for (int i = 0; i < n; i++) begin
      tick;
      chk("seq_s0", to_S_s0, 8'hA5 ^ m[7:0]);
      chk("seq_s1", to_S_s1, 8'h0F ^ m[7:0]);
      m = ref_step(m);
    end
    r_out = m;
  endtask

  task automatic reseed(input logic [31:0] seed);
    seed_valid = 1;
    seed_data = seed;
    chk("seed_ready_run", 32'(seed_ready), 1);
    tick;
    seed_valid = 0;
    chk("accept_running", 32'(running), 0);
    chk("accept_out", {to_S_s0, to_S_s1}, 0);
    warm_run(seed, 8, r);
  endtask

  initial begin
    int diff;
    logic [7:0] msk;
    tv[0] = '{1'b0, 8'h3C, 8'hC3, 8'hFF};
    tv[1] = '{1'b0, 8'h00, 8'h00, 8'h00};
    tv[2] = '{1'b0, 8'hFF, 8'h00, 8'hFF};
    tv[3] = '{1'b0, 8'h12, 8'h34, 8'h26};
    tv[4] = '{1'b1, 8'h5A, 8'h5A, 8'h00};
    tv[5] = '{1'b1, 8'h80, 8'h01, 8'h81};
    tv[6] = '{1'b1, 8'hFF, 8'hFF, 8'h00};
    tv[7] = '{1'b1, 8'h69, 8'h96, 8'hFF};
    tv[8] = '{1'b0, 8'h01, 8'h02, 8'h03};
    rst_n = 0; refresh_en = 1; seed_valid = 0; seed_data = 0;
    from_N_s0 = 8'hA5; from_N_s1 = 8'h0F;
    tick; tick;
    chk("rst_s0", to_S_s0, 0);
    chk("rst_s1", to_S_s1, 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_seed_ready", 32'(seed_ready), 0);
    rst_n = 1;
    warm_run(SEED, 0, r);
    chk("run_running", 32'(running), 1);
    chk("run_seed_ready", 32'(seed_ready), 1);
    diff = 0;
    for (int i = 0; i < 100; i++) begin
      tick;
      chk("refresh_xor", to_S_s0 ^ to_S_s1, 8'hAA);
      chk("refresh_s0", to_S_s0, 8'hA5 ^ r[7:0]);
      if (to_S_s0 != 8'hA5) diff++;
      r = ref_step(r);
    end
    chk("refresh_masked_ge90", 32'(diff >= 90), 1);
    refresh_en = 0;
    from_N_s0 = 8'h3C; from_N_s1 = 8'hC3;
    for (int i = 1; i <= LAT; i++) begin
      tick;
      chk("plain_lat_s0", to_S_s0, (i < LAT) ? 8'hA5 : 8'h3C);
      chk("plain_lat_s1", to_S_s1, (i < LAT) ? 8'h0F : 8'hC3);
    end
    repeat (5) tick;
    chk("plain_hold", {to_S_s0, to_S_s1}, 16'h3CC3);
    refresh_en = 1;
    tick;
    chk("frozen_mask", to_S_s0, 8'h3C ^ r[7:0]);
    r = ref_step(r);
    for (int k = 0; k < 9; k++) begin
      refresh_en = tv[k].en;
      from_N_s0 = tv[k].a0;
      from_N_s1 = tv[k].a1;
      msk = 0;
      for (int j = 0; j < LAT; j++) begin
        tick;
        msk = tv[k].en ? r[7:0] : 8'h00;
        if (tv[k].en) r = ref_step(r);
      end
      chk("vec_xor", to_S_s0 ^ to_S_s1, tv[k].exp_x);
      chk("vec_s0", to_S_s0, tv[k].a0 ^ msk);
    end
    refresh_en = 1; from_N_s0 = 8'hA5; from_N_s1 = 8'h0F;
    reseed(32'h0);
    reseed(32'h1234_5678);
    seed_valid = 1; seed_data = 32'hDEAD_BEEF;
    tick;
    seed_data = 32'h0BAD_F00D;
    warm_run(32'hDEAD_BEEF, 0, r);
    chk("warm_valid_ready", 32'(seed_ready), 1);
    tick;
    chk("accept_first_run", 32'(running), 0);
    seed_valid = 0;
    warm_run(32'h0BAD_F00D, 8, r);
    rst_n = 0;
    tick;
    chk("midrun_rst_out", {to_S_s0, to_S_s1}, 0);
    chk("midrun_rst_running", 32'(running), 0);
    rst_n = 1;
    warm_run(SEED, 8, r);
    rst_n = 0;
    tick;
    rst_n = 1;
    repeat (10) tick;
    rst_n = 0;
    tick;
    chk("midwarm_rst_running", 32'(running), 0);
    rst_n = 1;
    warm_run(SEED, 8, r);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
